// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: instruction fields, opcodes, fetch FSM states.
// Imported by the fetch unit and its next-PC helper.
package nrisc_pkg;

  localparam int INSTR_W = 8;

  localparam logic [2:0] OP_MISC   = 3'b110;
  localparam logic [2:0] OP_BEQ    = 3'b111;
  localparam logic [1:0] FUNC_HALT = 2'b11;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int FUNC_MSB = 1;
  localparam int FUNC_LSB = 0;
  localparam int OFF_MSB  = 4;
  localparam int OFF_LSB  = 0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    ISSUE,
    HALT
  } fetch_state_e;

  function automatic logic is_beq(
    input logic [INSTR_W-1:0] ins
  );
    return ins[OPC_MSB:OPC_LSB] == OP_BEQ;
  endfunction

  function automatic logic is_halt(
    input logic [INSTR_W-1:0] ins
  );
    return ins[OPC_MSB:OPC_LSB] == OP_MISC
        && ins[FUNC_MSB:FUNC_LSB] == FUNC_HALT;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: taken beq adds the sign-extended 5-bit offset, else +1.
// Ports: pc_i, instr_i, branch_cond_i -> next_pc_o (wraps modulo 2^PC_W).
module pc_next_calc
  import nrisc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               branch_cond_i,
  output logic [PC_W-1:0]    next_pc_o
);

  logic signed [OFF_MSB-OFF_LSB:0] off;
  logic [PC_W-1:0]                 off_sx;

  assign off    = instr_i[OFF_MSB:OFF_LSB];
  assign off_sx = PC_W'(off);

  always_comb begin
    next_pc_o = pc_i + PC_W'(1);
    if (is_beq(instr_i) && branch_cond_i)
      next_pc_o = pc_i + off_sx;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads imem via req/rvalid, issues instr via valid/ready.
// Ports: clk, rst_n, imem_* (memory side), instr/instr_valid/instr_ready/instr_pc, branch_cond, halted.
module instruction_fetch
  import nrisc_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               branch_cond,
  output logic               halted
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [PC_W-1:0]    next_pc;

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc_i         (pc_q),
    .instr_i      (instr_q),
    .branch_cond_i(branch_cond),
    .next_pc_o    (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      FETCH: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TIMEOUT - 1))
            state_d = FETCH;
        end
      end
      ISSUE: begin
        // valid_q gate: no retire in the cycle valid first rises
        if (instr_ready && valid_q) begin
          valid_d = 1'b0;
          if (is_halt(instr_q)) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  // state is FETCH while reset is held; keep req low until it releases
  assign imem_req    = (state_q == FETCH) && rst_n;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequencing, branches, wrap, timeout, stall, halt.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = '0;
  logic       imem_rvalid = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_pc;
  logic       branch_cond = 1'b0;
  logic       halted;

  int errs = 0;
  int checks = 0;

  instruction_fetch #(
    .PC_W    (8),
    .RESET_PC(8'h00),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_pc   (instr_pc),
    .branch_cond(branch_cond),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(
    input string      tag,
    input logic [7:0] exp_addr
  );
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
  endtask

  task automatic serve(
    input string      tag,
    input logic [7:0] data,
    input logic       cond,
    input logic [7:0] exp_addr
  );
    wait_req(tag, exp_addr);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    instr_ready = 1'b1;
    branch_cond = cond;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check({tag, "_vld"}, 32'(instr_valid), 32'd1);
    check({tag, "_ins"}, 32'(instr), 32'(data));
    check({tag, "_ipc"}, 32'(instr_pc), 32'(exp_addr));
    @(negedge clk);
    instr_ready = 1'b0;
    branch_cond = 1'b0;
    check({tag, "_drop"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_vld"}, 32'(instr_valid), 32'd0);
    check({tag, "_halt"}, 32'(halted), 32'd0);
    check({tag, "_ins"}, 32'(instr), 32'h00);
    check({tag, "_ipc"}, 32'(instr_pc), 32'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    int gap;
    int reqs;
    do_reset("rst0");

    serve("seq0", 8'h21, 1'b0, 8'h00);
    serve("fwd15", 8'hEF, 1'b1, 8'h01);
    serve("beq_t", 8'hE3, 1'b1, 8'h10);
    serve("seq13", 8'h21, 1'b0, 8'h13);
    serve("back4", 8'hFC, 1'b1, 8'h14);
    serve("beq_nt", 8'hE3, 1'b0, 8'h10);
    serve("back16", 8'hF0, 1'b1, 8'h11);
    serve("neg_wr", 8'hFE, 1'b1, 8'h01);
    serve("top_wr", 8'h21, 1'b0, 8'hFF);
    serve("cnd_ign", 8'h21, 1'b1, 8'h00);
    serve("misc", 8'hC1, 1'b1, 8'h01);

    wait_req("tmo0", 8'h02);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!imem_req && gap < 40);
    check("tmo_gap", 32'(gap), 32'd16);
    check("tmo_addr", 32'(imem_addr), 32'h02);
    imem_rvalid = 1'b1;
    imem_rdata  = 8'h55;
    @(negedge clk);
    imem_rdata  = 8'h21;
    instr_ready = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_vld", 32'(instr_valid), 32'd1);
    check("late_ins", 32'(instr), 32'h21);
    @(negedge clk);
    instr_ready = 1'b0;

    wait_req("stall", 8'h03);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 8'h22;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stl_vld", 32'(instr_valid), 32'd1);
      check("stl_ins", 32'(instr), 32'h22);
      check("stl_ipc", 32'(instr_pc), 32'h03);
      check("stl_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("isrst_vld", 32'(instr_valid), 32'd0);
    check("isrst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;

    serve("halt", 8'hC3, 1'b0, 8'h00);
    check("halted", 32'(halted), 32'd1);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) reqs++;
      @(negedge clk);
    end
    check("halt_noreq", 32'(reqs), 32'd0);
    check("halt_stay", 32'(halted), 32'd1);
    do_reset("rst1");
    wait_req("after_rst", 8'h00);
    serve("post", 8'h21, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
